// File: rtl/systolic_ctrl_if.sv
// Bundle between the systolic sequencer, its host/operand side and the array edge ports.
// master: host side; slave: the sequencer.
interface systolic_ctrl_if #(
    parameter int SIZE     = 3,
    parameter int IN_WIDTH = 8
);
    logic                                     start;
    logic                                     abort;
    logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0]  a_mat;
    logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0]  b_mat;
    logic                                     busy;
    logic                                     done;
    logic                                     arr_reset;
    logic                                     load_en;
    logic                                     mult_en;
    logic                                     acc_en;
    logic [SIZE-1:0][IN_WIDTH-1:0]            a_in;
    logic [SIZE-1:0][IN_WIDTH-1:0]            b_in;

    modport master (
        output start, abort, a_mat, b_mat,
        input  busy, done, arr_reset, load_en, mult_en, acc_en, a_in, b_in
    );

    modport slave (
        input  start, abort, a_mat, b_mat,
        output busy, done, arr_reset, load_en, mult_en, acc_en, a_in, b_in
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for a SIZE x SIZE output-stationary systolic multiplier: latches A/B, clears the
// array, streams skewed rows/columns into its edges, drains, then pulses done.
module systolic_ctrl #(
    parameter int SIZE     = 3,
    parameter int IN_WIDTH = 8,
    parameter int PE_LAT   = 1
) (
    input  logic           clk,
    input  logic           reset,
    systolic_ctrl_if.slave bus
);
    localparam int CW = $clog2(2*SIZE + PE_LAT);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2*SIZE - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(SIZE - 2 + PE_LAT);

    typedef logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0] mat_t;
    typedef logic [SIZE-1:0][IN_WIDTH-1:0]           vec_t;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mat_t          a_lat_q, a_lat_d;
    mat_t          b_lat_q, b_lat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          arr_reset_q, arr_reset_d;
    logic          en_q, en_d;
    vec_t          a_in_q, a_in_d;
    vec_t          b_in_q, b_in_d;
    logic          abort_hit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_lat_d   = a_lat_q;
        b_lat_d   = b_lat_q;
        abort_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_lat_d = bus.a_mat;
                    b_lat_d = bus.b_mat;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (bus.abort) begin
                    abort_hit = 1'b1;
                end else begin
                    state_d = FEED;
                    cnt_d   = '0;
                end
            end
            FEED: begin
                if (bus.abort) begin
                    abort_hit = 1'b1;
                end else if (cnt_q == FEED_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    abort_hit = 1'b1;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // Outputs are registered, so they are derived from where the FSM is heading.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        arr_reset_d = !((state_d == CLEAR) || abort_hit);
        en_d        = (state_d == FEED) || (state_d == DRAIN);

        a_in_d = '0;
        b_in_d = '0;
        if (state_d == FEED) begin
            // Diagonal skew: element m of row/column i enters on feed cycle k = i + m.
            for (int i = 0; i < SIZE; i++) begin
                for (int m = 0; m < SIZE; m++) begin
                    if (int'(cnt_d) == i + m) begin
                        a_in_d[i] = a_lat_q[i][m];
                        b_in_d[i] = b_lat_q[m][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_lat_q     <= '0;
            b_lat_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arr_reset_q <= 1'b1;
            en_q        <= 1'b0;
            a_in_q      <= '0;
            b_in_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_lat_q     <= a_lat_d;
            b_lat_q     <= b_lat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            arr_reset_q <= arr_reset_d;
            en_q        <= en_d;
            a_in_q      <= a_in_d;
            b_in_q      <= b_in_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.arr_reset = arr_reset_q;
    assign bus.load_en   = en_q;
    assign bus.mult_en   = en_q;
    assign bus.acc_en    = en_q;
    assign bus.a_in      = a_in_q;
    assign bus.b_in      = b_in_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: a behavioural output-stationary array is driven by the
// DUT edge ports; a monitor checks fed operands and the final product against queued values.
module tb_systolic_ctrl;
    localparam int SIZE = 3;
    localparam int W    = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    systolic_ctrl_if #(.SIZE(SIZE), .IN_WIDTH(W)) bus();

    systolic_ctrl #(.SIZE(SIZE), .IN_WIDTH(W), .PE_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int c [3][3]; } exp_t;
    typedef struct { logic [23:0] a; logic [23:0] b; } feed_t;

    exp_t  expQ[$];
    feed_t feedQ[$];
    int    total     = 0;
    int    passed    = 0;
    int    acceptCnt = 0;

    int acc [3][3];
    int ar  [3][3];
    int br  [3][3];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [23:0] v3(input int x0, input int x1, input int x2);
        return {8'(x2), 8'(x1), 8'(x0)};
    endfunction

    // pat 0: M fed as A rows, 1: M fed as B columns, 2: identity, 3: 2*identity
    function automatic logic [23:0] feedVec(input int pat, input int k);
        logic [23:0] r;
        int s;
        r = '0;
        s = pat - 1;
        case (pat)
            0: case (k)
                   0: r = v3(1, 0, 0);
                   1: r = v3(2, 4, 0);
                   2: r = v3(3, 5, 7);
                   3: r = v3(0, 6, 8);
                   4: r = v3(0, 0, 9);
                   default: r = '0;
               endcase
            1: case (k)
                   0: r = v3(1, 0, 0);
                   1: r = v3(4, 2, 0);
                   2: r = v3(7, 5, 3);
                   3: r = v3(0, 8, 6);
                   4: r = v3(0, 0, 9);
                   default: r = '0;
               endcase
            default: case (k)
                   0: r = v3(s, 0, 0);
                   2: r = v3(0, s, 0);
                   4: r = v3(0, 0, s);
                   default: r = '0;
               endcase
        endcase
        return r;
    endfunction

    // kind 0: A=B=M, 1: A=I B=2I, 2: A=M B=I, 3: A=I B=M
    function automatic exp_t expC(input int kind);
        exp_t e;
        case (kind)
            0:       e.c = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
            1:       e.c = '{'{2, 0, 0}, '{0, 2, 0}, '{0, 0, 2}};
            default: e.c = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        endcase
        return e;
    endfunction

    task automatic setMats(input int kind);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int m, id;
                m  = 3*i + j + 1;
                id = (i == j) ? 1 : 0;
                bus.a_mat[i][j] = 8'((kind == 0 || kind == 2) ? m : id);
                case (kind)
                    0, 3:    bus.b_mat[i][j] = 8'(m);
                    1:       bus.b_mat[i][j] = 8'(2*id);
                    default: bus.b_mat[i][j] = 8'(id);
                endcase
            end
        end
    endtask

    task automatic applyStimulus(input int kind, input int nfeed, input bit withC, input bit hold);
        int apat, bpat;
        apat = (kind == 0 || kind == 2) ? 0 : 2;
        case (kind)
            0, 3:    bpat = 1;
            1:       bpat = 3;
            default: bpat = 2;
        endcase
        setMats(kind);
        for (int k = 0; k < nfeed; k++) begin
            feed_t f;
            f.a = feedVec(apat, k);
            f.b = feedVec(bpat, k);
            feedQ.push_back(f);
        end
        if (withC) expQ.push_back(expC(kind));
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        checkOutput("accept busy", bus.busy, 1);
        checkOutput("clear arr_reset", bus.arr_reset, 0);
        checkOutput("clear load_en", bus.load_en, 0);
    endtask

    task automatic waitDone(input int maxCyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < maxCyc && !seen; n++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        checkOutput("done seen", seen, 1);
    endtask

    // Behavioural output-stationary array: A moves right, B moves down, each PE accumulates.
    always @(posedge clk) begin : arrayModel
        int al, bl;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!bus.arr_reset) begin
                    acc[i][j] <= 0;
                    ar[i][j]  <= 0;
                    br[i][j]  <= 0;
                end else if (bus.load_en && bus.mult_en && bus.acc_en) begin
                    if (j == 0) al = int'(bus.a_in[i]);
                    else        al = ar[i][j-1];
                    if (i == 0) bl = int'(bus.b_in[j]);
                    else        bl = br[i-1][j];
                    acc[i][j] <= acc[i][j] + al * bl;
                    ar[i][j]  <= al;
                    br[i][j]  <= bl;
                end
            end
        end
    end

    initial begin : monitor
        bit    busyPrev;
        int    cyc, accCyc;
        feed_t f;
        exp_t  e;
        busyPrev = 1'b0;
        cyc      = 0;
        accCyc   = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy && !busyPrev) begin
                acceptCnt++;
                accCyc = cyc;
            end
            busyPrev = bus.busy;
            if (bus.load_en) begin
                checkOutput("mult_en with load_en", bus.mult_en, 1);
                checkOutput("acc_en with load_en", bus.acc_en, 1);
                checkOutput("feed expected", feedQ.size() > 0, 1);
                if (feedQ.size() > 0) begin
                    f = feedQ.pop_front();
                    checkOutput("a_in", bus.a_in, f.a);
                    checkOutput("b_in", bus.b_in, f.b);
                end
            end
            if (bus.done) begin
                checkOutput("done latency", cyc - accCyc, 9);
                checkOutput("done enables off", bus.load_en, 0);
                checkOutput("done busy", bus.busy, 1);
                checkOutput("done expected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            checkOutput($sformatf("C[%0d][%0d]", i, j), acc[i][j], e.c[i][j]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        bus.start = 1'b1;
        bus.abort = 1'b0;
        setMats(0);

        repeat (3) @(negedge clk);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset arr_reset", bus.arr_reset, 1);
        checkOutput("reset load_en", bus.load_en, 0);
        checkOutput("reset mult_en", bus.mult_en, 0);
        checkOutput("reset acc_en", bus.acc_en, 0);
        checkOutput("reset a_in", bus.a_in, 0);
        checkOutput("reset b_in", bus.b_in, 0);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);

        // Full product of M*M
        applyStimulus(0, 8, 1'b1, 1'b0);
        waitDone(30);

        // Back-to-back in the first IDLE cycle; product must show no residue
        @(negedge clk);
        applyStimulus(1, 8, 1'b1, 1'b0);
        waitDone(30);

        // start held through the run while the source matrices change
        @(negedge clk);
        applyStimulus(2, 8, 1'b1, 1'b1);
        bus.a_mat = '1;
        bus.b_mat = '1;
        waitDone(30);
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("idle after done busy", bus.busy, 0);
        @(negedge clk);
        checkOutput("single accept count", acceptCnt, 3);

        // Abort during feed cycle k=2, then a fresh run
        applyStimulus(0, 3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("abort busy", bus.busy, 0);
        checkOutput("abort arr_reset", bus.arr_reset, 0);
        checkOutput("abort load_en", bus.load_en, 0);
        checkOutput("abort done", bus.done, 0);
        checkOutput("abort a_in", bus.a_in, 0);
        @(negedge clk);
        checkOutput("abort arr_reset release", bus.arr_reset, 1);
        applyStimulus(3, 8, 1'b1, 1'b0);
        waitDone(30);

        // Asynchronous reset during the first drain cycle
        @(negedge clk);
        applyStimulus(0, 6, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("async reset busy", bus.busy, 0);
        checkOutput("async reset done", bus.done, 0);
        checkOutput("async reset arr_reset", bus.arr_reset, 1);
        checkOutput("async reset load_en", bus.load_en, 0);
        checkOutput("async reset a_in", bus.a_in, 0);
        checkOutput("async reset b_in", bus.b_in, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post reset busy", bus.busy, 0);

        checkOutput("feed queue drained", feedQ.size(), 0);
        checkOutput("result queue drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
